// File: rtl/kiu_ext_int_receiver_pkg.sv
// Shared types and default handler vectors for the kernel interrupt unit receiver.
package kiu_ext_int_receiver_pkg;

  localparam int unsigned VEC_W = 32;

  localparam logic [VEC_W-1:0] DEF_IRQ_VECTOR = 32'h0000_0008;
  localparam logic [VEC_W-1:0] DEF_URQ_VECTOR = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PENDING   = 2'd1,
    ST_WAIT_DROP = 2'd2
  } kiu_state_e;

endpackage

// File: rtl/kiu_ext_int_receiver_sync_chain.sv
// Parameterized-depth single-bit synchronizer, synchronous active-high reset.
module kiu_ext_int_receiver_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/kiu_ext_int_receiver.sv
// CPU-side receiver of the EIC request/toggle-acknowledge interrupt protocol.
// Define KIU_URQ_NMI_EN to make urgent requests bypass CPU_IntEnable.
module kiu_ext_int_receiver
  import kiu_ext_int_receiver_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [VEC_W-1:0] IRQ_VECTOR  = DEF_IRQ_VECTOR,
  parameter logic [VEC_W-1:0] URQ_VECTOR  = DEF_URQ_VECTOR
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             EIC_IntReq,
  input  logic             EIC_IntId,
  output logic             EIC_IntAck,
  input  logic             CPU_IntEnable,
  input  logic             CPU_IntTaken,
  output logic             KIU_IntPending,
  output logic             KIU_IntUrgent,
  output logic [VEC_W-1:0] KIU_IntVector
);

  logic       req_sync;
  logic       id_sync;
  logic       req_last_q;
  logic       urgent_q, urgent_d;
  logic       ack_q, ack_d;
  logic       pending;
  logic       take;
  logic       req_rise;
  kiu_state_e state_q, state_d;

  kiu_ext_int_receiver_sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (Clock),
    .rst (Reset),
    .d_i (EIC_IntReq),
    .q_o (req_sync)
  );

  kiu_ext_int_receiver_sync_chain #(.STAGES(SYNC_STAGES)) u_id_sync (
    .clk (Clock),
    .rst (Reset),
    .d_i (EIC_IntId),
    .q_o (id_sync)
  );

  // State register plus the datapath flops it steers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      req_last_q <= 1'b0;
      urgent_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_last_q <= req_sync;
      urgent_q   <= urgent_d;
      ack_q      <= ack_d;
    end
  end

  assign req_rise = req_sync & ~req_last_q;
  assign take     = CPU_IntTaken & pending;

  always_comb begin
    state_d  = state_q;
    urgent_d = urgent_q;
    ack_d    = ack_q;
    case (state_q)
      ST_IDLE: begin
        if (req_rise) begin
          urgent_d = id_sync;
          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (take) begin
          ack_d   = ~ack_q;
          state_d = ST_WAIT_DROP;
        end
      end
      ST_WAIT_DROP: begin
        // Hold off until the EIC has dropped the already-acknowledged request.
        if (!req_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending = 1'b0;
`ifdef KIU_URQ_NMI_EN
    pending = (state_q == ST_PENDING) & (CPU_IntEnable | urgent_q);
`else
    pending = (state_q == ST_PENDING) & CPU_IntEnable;
`endif
  end

  assign EIC_IntAck     = ack_q;
  assign KIU_IntPending = pending;
  assign KIU_IntUrgent  = urgent_q;
  assign KIU_IntVector  = urgent_q ? URQ_VECTOR : IRQ_VECTOR;

endmodule

// File: tb/tb_kiu_ext_int_receiver.sv
// Directed self-checking bench for kiu_ext_int_receiver (default parameters).
`timescale 1ns/1ps
module tb_kiu_ext_int_receiver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        EIC_IntReq;
  logic        EIC_IntId;
  logic        EIC_IntAck;
  logic        CPU_IntEnable;
  logic        CPU_IntTaken;
  logic        KIU_IntPending;
  logic        KIU_IntUrgent;
  logic [31:0] KIU_IntVector;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  kiu_ext_int_receiver dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .EIC_IntReq     (EIC_IntReq),
    .EIC_IntId      (EIC_IntId),
    .EIC_IntAck     (EIC_IntAck),
    .CPU_IntEnable  (CPU_IntEnable),
    .CPU_IntTaken   (CPU_IntTaken),
    .KIU_IntPending (KIU_IntPending),
    .KIU_IntUrgent  (KIU_IntUrgent),
    .KIU_IntVector  (KIU_IntVector)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic take_pulse();
    CPU_IntTaken = 1'b1;
    tick();
    CPU_IntTaken = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; EIC_IntReq = 1'b0; EIC_IntId = 1'b0;
    CPU_IntEnable = 1'b1; CPU_IntTaken = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick();
    tests++;
    if (EIC_IntAck !== 1'b0) begin
      fails++; $display("FAIL reset_ack got=%b exp=0", EIC_IntAck);
    end
    tests++;
    if (KIU_IntPending !== 1'b0 || KIU_IntUrgent !== 1'b0) begin
      fails++; $display("FAIL reset_pend_urg got=%b%b exp=00", KIU_IntPending, KIU_IntUrgent);
    end
    tests++;
    if (KIU_IntVector !== 32'h8) begin
      fails++; $display("FAIL reset_vector got=%h exp=00000008", KIU_IntVector);
    end
  endtask

  task automatic test_basic_irq();
    logic [2:0] seen;
    EIC_IntId = 1'b0; EIC_IntReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen[i] = KIU_IntPending;
    end
    tests++;
    if (seen !== 3'b100) begin
      fails++; $display("FAIL req_latency pending_by_edge=%b exp=100", seen);
    end
    tests++;
    if (KIU_IntVector !== 32'h8 || KIU_IntUrgent !== 1'b0) begin
      fails++; $display("FAIL irq_vector got=%h urg=%b exp=00000008 urg=0", KIU_IntVector, KIU_IntUrgent);
    end
    take_pulse();
    tests++;
    if (EIC_IntAck !== 1'b1 || KIU_IntPending !== 1'b0) begin
      fails++; $display("FAIL first_ack ack=%b pend=%b exp ack=1 pend=0", EIC_IntAck, KIU_IntPending);
    end
  endtask

  task automatic test_stale_req();
    int stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (KIU_IntPending !== 1'b0) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++; $display("FAIL stale_req pending_cycles=%0d exp=0", stale);
    end
    EIC_IntReq = 1'b0;
    tick(4);
    EIC_IntReq = 1'b1;
    tick(3);
    tests++;
    if (KIU_IntPending !== 1'b1) begin
      fails++; $display("FAIL rearm_pending got=%b exp=1", KIU_IntPending);
    end
    take_pulse();
    tests++;
    if (EIC_IntAck !== 1'b0) begin
      fails++; $display("FAIL second_ack got=%b exp=0", EIC_IntAck);
    end
    EIC_IntReq = 1'b0;
    tick(4);
  endtask

  task automatic test_mask_urgent();
    CPU_IntEnable = 1'b0; EIC_IntId = 1'b1; EIC_IntReq = 1'b1;
    tick(3);
`ifdef KIU_URQ_NMI_EN
    tests++;
    if (KIU_IntPending !== 1'b1) begin
      fails++; $display("FAIL urq_nmi_pending got=%b exp=1", KIU_IntPending);
    end
`else
    tests++;
    if (KIU_IntPending !== 1'b0) begin
      fails++; $display("FAIL urq_masked_pending got=%b exp=0", KIU_IntPending);
    end
`endif
    tests++;
    if (KIU_IntVector !== 32'h4 || KIU_IntUrgent !== 1'b1) begin
      fails++; $display("FAIL urq_vector got=%h urg=%b exp=00000004 urg=1", KIU_IntVector, KIU_IntUrgent);
    end
    CPU_IntEnable = 1'b1;
    #1;
    tests++;
    if (KIU_IntPending !== 1'b1) begin
      fails++; $display("FAIL urq_enabled_pending got=%b exp=1", KIU_IntPending);
    end
    take_pulse();
    tests++;
    if (EIC_IntAck !== 1'b1 || KIU_IntPending !== 1'b0) begin
      fails++; $display("FAIL urq_ack ack=%b pend=%b exp ack=1 pend=0", EIC_IntAck, KIU_IntPending);
    end
    EIC_IntReq = 1'b0; EIC_IntId = 1'b0;
    tick(4);
  endtask

  task automatic test_taken_ignored();
    take_pulse();
    tick();
    tests++;
    if (EIC_IntAck !== 1'b1 || KIU_IntPending !== 1'b0) begin
      fails++; $display("FAIL idle_taken ack=%b pend=%b exp ack=1 pend=0", EIC_IntAck, KIU_IntPending);
    end
    CPU_IntEnable = 1'b0; EIC_IntId = 1'b0; EIC_IntReq = 1'b1;
    tick(3);
    tests++;
    if (KIU_IntPending !== 1'b0) begin
      fails++; $display("FAIL masked_pending got=%b exp=0", KIU_IntPending);
    end
    take_pulse();
    tick();
    tests++;
    if (EIC_IntAck !== 1'b1) begin
      fails++; $display("FAIL masked_taken_ack got=%b exp=1", EIC_IntAck);
    end
    CPU_IntEnable = 1'b1;
    #1;
    tests++;
    if (KIU_IntPending !== 1'b1) begin
      fails++; $display("FAIL unmask_retained got=%b exp=1", KIU_IntPending);
    end
  endtask

  task automatic test_id_change();
    EIC_IntId = 1'b1;
    tick(4);
    tests++;
    if (KIU_IntUrgent !== 1'b0 || KIU_IntVector !== 32'h8 || KIU_IntPending !== 1'b1) begin
      fails++; $display("FAIL id_frozen urg=%b vec=%h pend=%b exp urg=0 vec=00000008 pend=1",
                        KIU_IntUrgent, KIU_IntVector, KIU_IntPending);
    end
    take_pulse();
    tests++;
    if (EIC_IntAck !== 1'b0) begin
      fails++; $display("FAIL id_change_ack got=%b exp=0", EIC_IntAck);
    end
    EIC_IntReq = 1'b0; EIC_IntId = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid();
    logic [2:0] seen;
    EIC_IntReq = 1'b1;
    tick(3);
    take_pulse();
    tests++;
    if (EIC_IntAck !== 1'b1) begin
      fails++; $display("FAIL pre_reset_ack got=%b exp=1", EIC_IntAck);
    end
    tick(2);
    Reset = 1'b1;
    tick();
    tests++;
    if (EIC_IntAck !== 1'b0 || KIU_IntPending !== 1'b0) begin
      fails++; $display("FAIL mid_reset ack=%b pend=%b exp ack=0 pend=0", EIC_IntAck, KIU_IntPending);
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen[i] = KIU_IntPending;
    end
    tests++;
    if (seen !== 3'b100) begin
      fails++; $display("FAIL retake_after_reset pending_by_edge=%b exp=100", seen);
    end
    take_pulse();
    tests++;
    if (EIC_IntAck !== 1'b1) begin
      fails++; $display("FAIL retake_ack got=%b exp=1", EIC_IntAck);
    end
  endtask

  initial begin
    test_reset();
    test_basic_irq();
    test_stale_req();
    test_mask_urgent();
    test_taken_ignored();
    test_id_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
